bus_mem_slave: RTL and testbench

Memory-side target for the memory access control state machine. Decodes the master's `as_n`/`wr_n`/`stop_n` bus strobes, inserts a programmable number of wait states, performs a read or write on an internal synchronous RAM, and returns the one-cycle `ack_n` the master waits on. Supports single transfers and incrementing bursts, and flags transfers aborted by the master.

---
 rtl/bus_mem_slave_pkg.sv | 24 ++
 rtl/sync_ram.sv | 37 +++
 rtl/bus_mem_slave.sv | 136 +++++++++++++
 tb/tb_bus_mem_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_slave_pkg.sv
// Shared types and defaults for the bus memory slave: FSM state encoding,
// default widths and the wait-counter width.
package bus_mem_slave_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 2;

  // Wait counter holds 0..15 wait states.
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Wait-counter load value for a given wait-state count.
  function automatic logic [WCNT_W-1:0] wait_load(input int n);
    return WCNT_W'(n);
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM with write enable and a registered, enable-gated read port.
// The read register holds its value when no read is issued; only the read
// register is cleared by reset, the array contents survive it.
module sync_ram
  import bus_mem_slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write; no reset so contents persist across resets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data, updated only when a read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Memory-side bus target: decodes as_n/wr_n/stop_n, inserts WAIT_CYCLES wait
// states per beat, reads or writes the internal RAM and returns ack_n.
//
// Handshake: the master drops as_n and holds it low for the whole
// transaction; wr_n and addr are captured on the first edge that sees as_n
// low. Each beat is acknowledged by a single-cycle ack_n low. During that
// cycle wdata must be stable (written at its closing edge) and rdata is valid
// on reads; stop_n low in that cycle marks the last beat. Raising as_n before
// a beat's ACK cycle aborts the transaction (abort pulses); raising it during
// ACK lets the beat complete and ends the transaction quietly. After the last
// beat the slave parks in HOLD until as_n is released.
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              as_n,
  input  logic              wr_n,
  input  logic              stop_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack_n,
  output logic              slave_busy,
  output logic              abort,
  output state_t            state_dbg
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = wait_load(WAIT_CYCLES);
  // Beats with no wait states go straight to ACK.
  localparam state_t BEAT_ENTRY = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              op_q, op_nxt;
  logic [WCNT_W-1:0] wcnt_q, wcnt_nxt;
  logic              abort_q, abort_nxt;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;

  // State, address, opcode, wait counter and abort pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= 1'b1;
      wcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      addr_q  <= addr_nxt;
      op_q    <= op_nxt;
      wcnt_q  <= wcnt_nxt;
      abort_q <= abort_nxt;
    end
  end

  // Next-state logic: transaction start, wait countdown, burst advance, abort.
  always_comb begin
    state_nxt = state_q;
    addr_nxt  = addr_q;
    op_nxt    = op_q;
    wcnt_nxt  = wcnt_q;
    abort_nxt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!as_n) begin
          addr_nxt  = addr;
          op_nxt    = wr_n;
          wcnt_nxt  = WCNT_LOAD;
          state_nxt = BEAT_ENTRY;
        end
      end
      S_WAIT: begin
        if (as_n) begin
          state_nxt = S_IDLE;
          abort_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt_q - 1'b1;
          if (wcnt_q == WCNT_W'(1)) begin
            state_nxt = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (as_n) begin
          state_nxt = S_IDLE;
        end else if (!stop_n) begin
          state_nxt = S_HOLD;
        end else begin
          // Incrementing burst; the address wraps naturally at the top.
          addr_nxt  = addr_q + 1'b1;
          wcnt_nxt  = WCNT_LOAD;
          state_nxt = BEAT_ENTRY;
        end
      end
      S_HOLD: begin
        if (as_n) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // RAM control: writes commit at the closing edge of ACK; reads are issued
  // in the cycle before ACK using the address the next beat will use.
  always_comb begin
    ram_we   = (state_q == S_ACK) && !op_q && !reset;
    ram_re   = (state_nxt == S_ACK) && op_nxt && !reset;
    ram_addr = ram_we ? addr_q : addr_nxt;
  end

  sync_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign ack_n      = (state_q != S_ACK);
  assign slave_busy = (state_q != S_IDLE);
  assign abort      = abort_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: one instance with two wait states and one
// with none, driven through shared bus signals with separate address strobes.
module tb_bus_mem_slave;
  import bus_mem_slave_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          as_n_a, as_n_b, wr_n, stop_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ack_n_a, ack_n_b, busy_a, busy_b, abort_a, abort_b;
  state_t        st_a, st_b;

  int checks = 0;
  int errors = 0;

  // Scoreboard: reference memories and expected read data queue
  logic [DW-1:0] model_a [256];
  logic [DW-1:0] model_b [256];
  logic [DW-1:0] exp_q[$];

  bus_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .as_n(as_n_a), .wr_n(wr_n), .stop_n(stop_n),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .ack_n(ack_n_a),
    .slave_busy(busy_a), .abort(abort_a), .state_dbg(st_a)
  );

  bus_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .as_n(as_n_b), .wr_n(wr_n), .stop_n(stop_n),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .ack_n(ack_n_b),
    .slave_busy(busy_b), .abort(abort_b), .state_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ack(input bit sel);
    return sel ? ack_n_b : ack_n_a;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic cur_abort(input bit sel);
    return sel ? abort_b : abort_a;
  endfunction
  function automatic logic [DW-1:0] cur_rdata(input bit sel);
    return sel ? rdata_b : rdata_a;
  endfunction
  function automatic logic [1:0] cur_state(input bit sel);
    return sel ? st_b : st_a;
  endfunction

  task automatic set_as(input bit sel, input logic v);
    if (sel) as_n_b = v;
    else as_n_a = v;
  endtask

  // Driver: one transaction of nbeats beats (wr=1 write, wr=0 read) on the
  // instance picked by sel. Write data for beat k is d0 + k*dstep. With
  // rel_in_ack the strobe is raised during the last ACK (stop_n also low).
  task automatic run_burst(input bit sel, input bit wr, input logic [AW-1:0] a0,
                           input int nbeats, input logic [DW-1:0] d0,
                           input logic [DW-1:0] dstep, input bit rel_in_ack);
    int            exp_lat;
    int            cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] expv;
    exp_lat = sel ? 1 : 3;
    a = a0;
    d = d0;
    if (!wr) begin
      for (int k = 0; k < nbeats; k++) begin
        expv = sel ? model_b[a0 + AW'(k)] : model_a[a0 + AW'(k)];
        exp_q.push_back(expv);
      end
    end
    @(negedge clk);
    set_as(sel, 1'b0);
    wr_n   = !wr;
    addr   = a0;
    wdata  = d0;
    stop_n = (nbeats == 1) ? 1'b0 : 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        wdata  = d;
        stop_n = (k == nbeats - 1) ? 1'b0 : 1'b1;
        // wr_n and addr are captured at the start; later changes must not matter
        if (k == 0 && cnt == 1) begin
          wr_n = ~wr_n;
          addr = ~addr;
        end
      end while (cur_ack(sel) && cnt < 20);
      check($sformatf("lat_beat%0d", k), cnt, exp_lat);
      if (!wr) begin
        expv = exp_q.pop_front();
        check($sformatf("rdata_%02h", a), cur_rdata(sel), expv);
      end else if (sel) begin
        model_b[a] = d;
      end else begin
        model_a[a] = d;
      end
      a = a + 1'b1;
      d = d + dstep;
      if (k == nbeats - 1 && rel_in_ack) set_as(sel, 1'b1);
    end
    if (rel_in_ack) begin
      @(negedge clk);
      check("rel_state_idle", cur_state(sel), S_IDLE);
      check("rel_no_abort", cur_abort(sel), 1'b0);
      check("rel_busy", cur_busy(sel), 1'b0);
    end else begin
      @(negedge clk);
      check("hold_state", cur_state(sel), S_HOLD);
      check("hold_busy", cur_busy(sel), 1'b1);
      @(negedge clk);
      check("hold_state2", cur_state(sel), S_HOLD);
      check("hold_no_ack", cur_ack(sel), 1'b1);
      set_as(sel, 1'b1);
      @(negedge clk);
      check("busy_fall", cur_busy(sel), 1'b0);
      check("idle_after", cur_state(sel), S_IDLE);
    end
  endtask

  initial begin
    reset  = 1'b1;
    as_n_a = 1'b1;
    as_n_b = 1'b1;
    wr_n   = 1'b1;
    stop_n = 1'b1;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(negedge clk);

    // Reset values on both instances
    check("rst_ack_a", ack_n_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_abort_a", abort_a, 1'b0);
    check("rst_rdata_a", rdata_a, 16'h0000);
    check("rst_state_a", st_a, S_IDLE);
    check("rst_ack_b", ack_n_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_abort_b", abort_b, 1'b0);
    check("rst_rdata_b", rdata_b, 16'h0000);
    check("rst_state_b", st_b, S_IDLE);
    reset = 1'b0;

    // Single write then single read, two wait states
    run_burst(1'b0, 1'b1, 8'h10, 1, 16'hBEEF, 16'h0000, 1'b0);
    run_burst(1'b0, 1'b0, 8'h10, 1, 16'h0000, 16'h0000, 1'b0);

    // Burst write across the address wrap, then read it back as a burst
    run_burst(1'b0, 1'b1, 8'hFE, 4, 16'h1111, 16'h1111, 1'b0);
    run_burst(1'b0, 1'b0, 8'hFE, 4, 16'h0000, 16'h0000, 1'b0);
    check("wrap_model_00", model_a[8'h00], 16'h3333);

    // Abort one cycle into WAIT on a write to 0x20
    run_burst(1'b0, 1'b1, 8'h20, 1, 16'h5A5A, 16'h0000, 1'b0);
    @(negedge clk);
    as_n_a = 1'b0; wr_n = 1'b0; addr = 8'h20; wdata = 16'hDEAD; stop_n = 1'b0;
    @(negedge clk);
    check("abort_in_wait", st_a, S_WAIT);
    check("abort_not_yet", abort_a, 1'b0);
    as_n_a = 1'b1;
    @(negedge clk);
    check("abort_pulse", abort_a, 1'b1);
    check("abort_no_ack", ack_n_a, 1'b1);
    check("abort_idle", st_a, S_IDLE);
    @(negedge clk);
    check("abort_clear", abort_a, 1'b0);
    run_burst(1'b0, 1'b0, 8'h20, 1, 16'h0000, 16'h0000, 1'b0);

    // Reset mid-WAIT during a write to 0x30
    run_burst(1'b0, 1'b1, 8'h30, 2, 16'h1234, 16'h4444, 1'b0);
    @(negedge clk);
    as_n_a = 1'b0; wr_n = 1'b0; addr = 8'h30; wdata = 16'hFFFF; stop_n = 1'b0;
    @(negedge clk);
    check("rst_mid_wait", st_a, S_WAIT);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", st_a, S_IDLE);
    check("rst_mid_ack", ack_n_a, 1'b1);
    check("rst_mid_busy", busy_a, 1'b0);
    check("rst_mid_rdata", rdata_a, 16'h0000);
    reset  = 1'b0;
    as_n_a = 1'b1;
    run_burst(1'b0, 1'b0, 8'h30, 2, 16'h0000, 16'h0000, 1'b0);
    run_burst(1'b0, 1'b0, 8'h10, 1, 16'h0000, 16'h0000, 1'b0);

    // Strobe raised together with stop_n in ACK: write and read still complete
    run_burst(1'b0, 1'b1, 8'h50, 1, 16'h7777, 16'h0000, 1'b1);
    run_burst(1'b0, 1'b0, 8'h50, 1, 16'h0000, 16'h0000, 1'b1);

    // Zero wait states: back-to-back beats
    run_burst(1'b1, 1'b1, 8'h40, 3, 16'hA001, 16'h0001, 1'b0);
    run_burst(1'b1, 1'b0, 8'h40, 3, 16'h0000, 16'h0000, 1'b0);
    run_burst(1'b1, 1'b0, 8'h41, 1, 16'h0000, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
